line_buffer_multi: RTL and testbench

- Parametrised multi-line buffer for the linebuffer pipeline.
- Accepts a raster pixel stream and presents a vertical column of NUM_TAPS pixels (current row plus NUM_TAPS-1 previous rows, same column) for window/filter stages.
- Holds NUM_TAPS-1 internal line memories, cascaded read-first, plus column/row tracking, start-of-frame restart and zero-gating of not-yet-filled rows.

---
 rtl/line_buffer_multi_if.sv | 26 ++
 rtl/line_buffer_multi.sv | 103 ++++++++++
 tb/tb_line_buffer_multi.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/line_buffer_multi_if.sv
// Pixel-stream bus for the multi-line buffer: raster input plus the registered
// vertical tap column presented to window/filter stages.
interface line_buffer_multi_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_TAPS   = 3
);
  logic                           sof;
  logic                           in_valid;
  logic [DATA_WIDTH-1:0]          data_in;
  logic                           out_valid;
  logic [NUM_TAPS*DATA_WIDTH-1:0] out_taps;
  logic [ADDR_WIDTH-1:0]          out_col;
  logic                           out_eol;
  logic                           out_win_valid;

  modport master (
    output sof, in_valid, data_in,
    input  out_valid, out_taps, out_col, out_eol, out_win_valid
  );

  modport slave (
    input  sof, in_valid, data_in,
    output out_valid, out_taps, out_col, out_eol, out_win_valid
  );
endinterface

// File: rtl/line_buffer_multi.sv
// Multi-line buffer: NUM_TAPS-1 cascaded read-first line memories produce a
// column of the current and previous rows, zero-gated until rows have filled.
module line_buffer_multi #(
  parameter int DATA_WIDTH = 16,
  parameter int LINE_LEN   = 1920,
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_TAPS   = 3
) (
  input logic                clk,
  input logic                rst_n,
  line_buffer_multi_if.slave bus
);
  localparam int ROW_W = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(LINE_LEN - 1);
  localparam logic [ROW_W-1:0]      ROW_MAX  = ROW_W'(NUM_TAPS - 1);

  logic [ADDR_WIDTH-1:0]          col_cnt;
  logic [ROW_W-1:0]               row_cnt;
  logic [ADDR_WIDTH-1:0]          col_p0;
  logic [ROW_W-1:0]               row_p0;
  logic [DATA_WIDTH-1:0]          rd_p0 [NUM_TAPS-1];
  logic [NUM_TAPS*DATA_WIDTH-1:0] taps_p0;

  logic                           vld_p1;
  logic [NUM_TAPS*DATA_WIDTH-1:0] taps_p1;
  logic [ADDR_WIDTH-1:0]          col_p1;
  logic                           eol_p1;
  logic                           win_p1;

  // Stage p0: sof forces the pixel to col 0 / row 0 before it is used
  assign col_p0 = bus.sof ? '0 : col_cnt;
  assign row_p0 = bus.sof ? '0 : row_cnt;

  // Line k stores what line k-1 held at this column, shifting rows down the cascade
  for (genvar k = 0; k < NUM_TAPS - 1; k++) begin : g_line
    logic [DATA_WIDTH-1:0] mem [LINE_LEN];
    logic [DATA_WIDTH-1:0] wr_p0;

    if (k == 0) begin : g_head
      assign wr_p0 = bus.data_in;
    end else begin : g_tail
      assign wr_p0 = rd_p0[k-1];
    end

    assign rd_p0[k] = mem[col_p0];

    always_ff @(posedge clk) begin
      if (bus.in_valid) mem[col_p0] <= wr_p0;
    end
  end

  // Taps older than the rows seen in this frame read stale memory and are forced to 0
  always_comb begin
    taps_p0 = '0;
    taps_p0[DATA_WIDTH-1:0] = bus.data_in;
    for (int k = 1; k < NUM_TAPS; k++) begin
      if (ROW_W'(k) <= row_p0) taps_p0[k*DATA_WIDTH +: DATA_WIDTH] = rd_p0[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (bus.in_valid) begin
      if (col_p0 == LAST_COL) begin
        col_cnt <= '0;
        row_cnt <= (row_p0 == ROW_MAX) ? row_p0 : row_p0 + 1'b1;
      end else begin
        col_cnt <= col_p0 + 1'b1;
        row_cnt <= row_p0;
      end
    end else if (bus.sof) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end
  end

  // Stage p1: registered outputs, held while no pixel is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      taps_p1 <= '0;
      col_p1  <= '0;
      eol_p1  <= 1'b0;
      win_p1  <= 1'b0;
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        taps_p1 <= taps_p0;
        col_p1  <= col_p0;
        eol_p1  <= (col_p0 == LAST_COL);
        win_p1  <= (row_p0 == ROW_MAX);
      end
    end
  end

  assign bus.out_valid     = vld_p1;
  assign bus.out_taps      = taps_p1;
  assign bus.out_col       = col_p1;
  assign bus.out_eol       = eol_p1;
  assign bus.out_win_valid = win_p1;
endmodule

// File: tb/tb_line_buffer_multi.sv
// Bench for line_buffer_multi: directed and random pixel streams compared
// against a frame-history model that indexes earlier rows by pixel count.
module tb_line_buffer_multi;
  localparam int DW = 8;
  localparam int L  = 4;
  localparam int AW = 2;
  localparam int T  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  line_buffer_multi_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TAPS(T)) bus ();

  line_buffer_multi #(
    .DATA_WIDTH(DW), .LINE_LEN(L), .ADDR_WIDTH(AW), .NUM_TAPS(T)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: every pixel of the current frame, in arrival order
  int            frame [$];
  logic          exp_vld;
  logic [T*DW-1:0] exp_taps;
  logic [AW-1:0] exp_col;
  logic          exp_eol;
  logic          exp_win;

  task automatic model_reset();
    frame.delete();
    exp_vld  = 1'b0;
    exp_taps = '0;
    exp_col  = '0;
    exp_eol  = 1'b0;
    exp_win  = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic v, input logic [DW-1:0] d);
    int n, row, col;
    if (s) frame.delete();
    exp_vld = v;
    if (v) begin
      n   = frame.size();
      col = n % L;
      row = n / L;
      exp_taps = '0;
      exp_taps[DW-1:0] = d;
      for (int k = 1; k < T; k++)
        if (row >= k) exp_taps[k*DW +: DW] = DW'(frame[n - k*L]);
      exp_col = AW'(col);
      exp_eol = (col == L - 1);
      exp_win = (row >= T - 1);
      frame.push_back(int'(d));
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(exp_vld));
    chk({tag, ".taps"},  32'(bus.out_taps),  32'(exp_taps));
    chk({tag, ".col"},   32'(bus.out_col),   32'(exp_col));
    chk({tag, ".eol"},   32'(bus.out_eol),   32'(exp_eol));
    chk({tag, ".win"},   32'(bus.out_win_valid), 32'(exp_win));
  endtask

  task automatic step(input string tag, input logic s, input logic v, input logic [DW-1:0] d);
    @(negedge clk);
    bus.sof      = s;
    bus.in_valid = v;
    bus.data_in  = d;
    model_step(s, v, d);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    bus.sof      = 1'b0;
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Three continuous rows, then row saturation
    for (int i = 1; i <= 12; i++) step("cont", i == 1, 1'b1, DW'(i));
    chk("cont_last_taps", 32'(bus.out_taps), 32'({8'd4, 8'd8, 8'd12}));
    chk("cont_last_eol", 32'(bus.out_eol), 32'd1);
    for (int i = 13; i <= 16; i++) step("sat", 1'b0, 1'b1, DW'(i));
    chk("sat_last_taps", 32'(bus.out_taps), 32'({8'd8, 8'd12, 8'd16}));

    // Same stream with random idle gaps
    for (int i = 1; i <= 12; i++) begin
      step("gap", i == 1, 1'b1, DW'(i));
      repeat ($urandom_range(0, 2)) step("gap_idle", 1'b0, 1'b0, DW'($urandom));
    end

    // Restart after full rows: old memory content must be hidden
    step("sof_restart", 1'b1, 1'b1, 8'd50);
    chk("sof_restart_taps", 32'(bus.out_taps), 32'({8'd0, 8'd0, 8'd50}));

    // Asynchronous reset in the middle of row 2
    for (int i = 1; i <= 10; i++) step("pre_rst", i == 1, 1'b1, DW'(i));
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_mid");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b0, 1'b1, 8'd77);
    chk("post_rst_taps", 32'(bus.out_taps), 32'({8'd0, 8'd0, 8'd77}));

    // sof with no pixel, then the next pixel starts a new frame
    for (int i = 1; i <= 6; i++) step("pre_sof", 1'b0, 1'b1, DW'(i));
    step("sof_alone", 1'b1, 1'b0, 8'd0);
    step("sof_idle", 1'b0, 1'b0, 8'd0);
    step("after_sof", 1'b0, 1'b1, 8'd20);
    chk("after_sof_col", 32'(bus.out_col), 32'd0);
    chk("after_sof_taps", 32'(bus.out_taps), 32'({8'd0, 8'd0, 8'd20}));

    // Random stream with random valid gaps and occasional sof
    for (int i = 0; i < 120; i++)
      step("rand", $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, DW'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
